// File: rtl/llc_port_arbiter_pkg.sv
// llc_arb_pkg: shared state encoding, line type and pointer wrap helper for llc_port_arbiter
package llc_arb_pkg;
  localparam int LINE_BITS = 64 * 8;
  typedef logic [LINE_BITS-1:0] line_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESPOND} arb_state_t;
  function automatic int unsigned rr_next(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/llc_port_arbiter_if.sv
// llc_port_arbiter_if: requester, response and lower-level buses of the shared cache port
interface llc_port_arbiter_if #(
  parameter int N_REQ     = 2,
  parameter int B         = 64,
  parameter int ADDR_BITS = 64
);
  logic [N_REQ-1:0]                req_valid_in;
  logic [N_REQ-1:0]                req_we_in;
  logic [N_REQ-1:0][ADDR_BITS-1:0] req_addr_in;
  logic [N_REQ-1:0][B*8-1:0]       req_value_in;
  logic [N_REQ-1:0]                req_ready_out;
  logic [N_REQ-1:0]                resp_valid_out;
  logic [ADDR_BITS-1:0]            resp_addr_out;
  logic [B*8-1:0]                  resp_value_out;
  logic [N_REQ-1:0]                resp_ready_in;
  logic                            lc_valid_out;
  logic                            lc_we_out;
  logic [ADDR_BITS-1:0]            lc_addr_out;
  logic [B*8-1:0]                  lc_value_out;
  logic                            lc_ready_in;
  logic                            lc_valid_in;
  logic [ADDR_BITS-1:0]            lc_addr_in;
  logic [B*8-1:0]                  lc_value_in;
  logic                            lc_ready_out;
  logic                            err_out;
  modport slave (
    input  req_valid_in, req_we_in, req_addr_in, req_value_in, resp_ready_in,
    input  lc_ready_in, lc_valid_in, lc_addr_in, lc_value_in,
    output req_ready_out, resp_valid_out, resp_addr_out, resp_value_out,
    output lc_valid_out, lc_we_out, lc_addr_out, lc_value_out, lc_ready_out, err_out
  );
  modport master (
    output req_valid_in, req_we_in, req_addr_in, req_value_in, resp_ready_in,
    output lc_ready_in, lc_valid_in, lc_addr_in, lc_value_in,
    input  req_ready_out, resp_valid_out, resp_addr_out, resp_value_out,
    input  lc_valid_out, lc_we_out, lc_addr_out, lc_value_out, lc_ready_out, err_out
  );
endinterface

// File: rtl/llc_port_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first requester at or above ptr
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         grant_valid
);
  int unsigned k;
  // scan from the farthest offset down so the nearest requester wins last
  always_comb begin
    grant = '0;
    grant_valid = 1'b0;
    k = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (32'(ptr) + 32'(i)) % N;
      if (req[k]) begin
        grant = W'(k);
        grant_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/llc_port_arbiter.sv
// llc_port_arbiter: round-robin share of one lower-level cache port, one transaction in flight
// Define LLC_ARB_TIMEOUT_EN to add the response watchdog that drives err_out.
import llc_arb_pkg::*;
module llc_port_arbiter #(
  parameter int N_REQ          = 2,
  parameter int B              = 64,
  parameter int ADDR_BITS      = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk_in,
  input logic rst_N_in,
  llc_port_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LB = B * 8;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  arb_state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, grant;
  logic gvalid, we_q, we_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d, raddr_q, raddr_d;
  logic [LB-1:0] wval_q, wval_d, rval_q, rval_d;
  logic iss, rsp;
`ifdef LLC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
`endif
  rr_arbiter #(.N(N_REQ), .W(IW)) u_rr (
    .req        (bus.req_valid_in),
    .ptr        (ptr_q),
    .grant      (grant),
    .grant_valid(gvalid)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    we_d = we_q;
    addr_d = addr_q;
    wval_d = wval_q;
    raddr_d = raddr_q;
    rval_d = rval_q;
`ifdef LLC_ARB_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    case (state_q)
      IDLE: if (gvalid) begin
        state_d = ISSUE;
        owner_d = grant;
        we_d = bus.req_we_in[grant];
        addr_d = bus.req_addr_in[grant];
        wval_d = bus.req_value_in[grant];
        ptr_d = IW'(rr_next(32'(grant), N_REQ));
      end
      ISSUE: if (bus.lc_ready_in) begin
        state_d = we_q ? IDLE : WAIT_RESP;
`ifdef LLC_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      WAIT_RESP: begin
`ifdef LLC_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CW'(1);
        if (!bus.lc_valid_in && cnt_d == CW'(TIMEOUT_CYCLES)) begin
          state_d = IDLE;
          err_d = 1'b1;
        end
`endif
        if (bus.lc_valid_in) begin
          state_d = RESPOND;
          raddr_d = bus.lc_addr_in;
          rval_d = bus.lc_value_in;
        end
      end
      RESPOND: if (bus.resp_ready_in[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wval_q <= '0;
      raddr_q <= '0;
      rval_q <= '0;
`ifdef LLC_ARB_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wval_q <= wval_d;
      raddr_q <= raddr_d;
      rval_q <= rval_d;
`ifdef LLC_ARB_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end
  assign iss = state_q == ISSUE;
  assign rsp = state_q == RESPOND;
  // the grant is combinational, so it is masked while reset holds the block quiet
  assign bus.req_ready_out = (rst_N_in && state_q == IDLE && gvalid) ? ONE << grant : '0;
  assign bus.lc_valid_out = iss;
  assign bus.lc_we_out = iss & we_q;
  assign bus.lc_addr_out = iss ? addr_q : '0;
  assign bus.lc_value_out = iss ? wval_q : '0;
  assign bus.lc_ready_out = state_q == WAIT_RESP;
  assign bus.resp_valid_out = rsp ? ONE << owner_q : '0;
  assign bus.resp_addr_out = rsp ? raddr_q : '0;
  assign bus.resp_value_out = rsp ? rval_q : '0;
`ifdef LLC_ARB_TIMEOUT_EN
  assign bus.err_out = err_q;
`else
  assign bus.err_out = 1'b0;
`endif
endmodule

// File: tb/tb_llc_port_arbiter.sv
// tb_llc_port_arbiter: transaction-level model compared every cycle plus directed literal checks
module tb_llc_port_arbiter;
  localparam int N = 2;
  localparam int B = 64;
  localparam int AW = 64;
  localparam int LB = B * 8;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  llc_port_arbiter_if #(.N_REQ(N), .B(B), .ADDR_BITS(AW)) bus ();
  llc_port_arbiter #(.N_REQ(N), .B(B), .ADDR_BITS(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in  (clk),
    .rst_N_in(rst_n),
    .bus     (bus)
  );
  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // abstract model: busy flag, phase of the single outstanding transaction, rotating pointer
  int m_ptr, m_own, m_stage, m_wcnt;
  bit m_busy, m_we, m_err;
  logic [AW-1:0] m_addr, m_raddr;
  logic [LB-1:0] m_val, m_rval;
  function automatic int first_valid();
    for (int k = 0; k < N; k++) if (bus.req_valid_in[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  function automatic logic [N-1:0] oh(input int i);
    oh = '0;
    oh[i] = 1'b1;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_ptr <= 0; m_err <= 0; m_stage <= 0; m_wcnt <= 0; m_own <= 0;
    end else if (!m_busy) begin
      if (first_valid() >= 0) begin
        m_busy <= 1; m_stage <= 0; m_own <= first_valid();
        m_we <= bus.req_we_in[first_valid()];
        m_addr <= bus.req_addr_in[first_valid()];
        m_val <= bus.req_value_in[first_valid()];
        m_ptr <= (first_valid() + 1) % N;
      end
    end else if (m_stage == 0) begin
      if (bus.lc_ready_in) begin
        if (m_we) m_busy <= 0;
        else begin m_stage <= 1; m_wcnt <= 0; end
      end
    end else if (m_stage == 1) begin
      if (bus.lc_valid_in) begin
        m_stage <= 2; m_raddr <= bus.lc_addr_in; m_rval <= bus.lc_value_in;
      end
`ifdef LLC_ARB_TIMEOUT_EN
      else begin
        m_wcnt <= m_wcnt + 1;
        if (m_wcnt + 1 == TO) begin m_busy <= 0; m_err <= 1; end
      end
`endif
    end else if (bus.resp_ready_in[m_own]) m_busy <= 0;
  end
  always @(negedge clk) if (rst_n) begin
    chk("req_ready", LB'(bus.req_ready_out), LB'((!m_busy && first_valid() >= 0) ? oh(first_valid()) : '0));
    chk("lc_valid", LB'(bus.lc_valid_out), LB'(m_busy && m_stage == 0));
    chk("lc_we", LB'(bus.lc_we_out), LB'(m_busy && m_stage == 0 && m_we));
    chk("lc_addr", LB'(bus.lc_addr_out), (m_busy && m_stage == 0) ? LB'(m_addr) : '0);
    chk("lc_value", bus.lc_value_out, (m_busy && m_stage == 0) ? m_val : '0);
    chk("lc_ready", LB'(bus.lc_ready_out), LB'(m_busy && m_stage == 1));
    chk("resp_valid", LB'(bus.resp_valid_out), LB'((m_busy && m_stage == 2) ? oh(m_own) : '0));
    chk("resp_addr", LB'(bus.resp_addr_out), (m_busy && m_stage == 2) ? LB'(m_raddr) : '0);
    chk("resp_value", bus.resp_value_out, (m_busy && m_stage == 2) ? m_rval : '0);
    chk("err", LB'(bus.err_out), LB'(m_err));
  end
  task automatic do_req(input int p, input bit we, input logic [AW-1:0] a, input logic [LB-1:0] v);
    int t;
    @(posedge clk); #1;
    bus.req_valid_in[p] = 1'b1; bus.req_we_in[p] = we; bus.req_addr_in[p] = a; bus.req_value_in[p] = v;
    for (t = 0; t < 200; t++) begin @(negedge clk); if (bus.req_ready_out[p]) break; end
    chk($sformatf("req%0d_grant", p), LB'(bus.req_ready_out[p]), LB'(1));
    @(posedge clk); #1;
    bus.req_valid_in[p] = 1'b0;
  endtask
  task automatic respond(input logic [AW-1:0] a, input logic [LB-1:0] v, input int d);
    int t;
    for (t = 0; t < 200; t++) begin @(negedge clk); if (bus.lc_ready_out) break; end
    chk("lc_ready_wait", LB'(bus.lc_ready_out), LB'(1));
    repeat (d) @(negedge clk);
    bus.lc_valid_in = 1'b1; bus.lc_addr_in = a; bus.lc_value_in = v;
    @(negedge clk);
    bus.lc_valid_in = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int ord[4];
    int n_ord, t, cnt;
    logic [AW-1:0] a;
    logic [LB-1:0] v4;
    bus.req_valid_in = '0; bus.req_we_in = '0; bus.req_addr_in = '0; bus.req_value_in = '0;
    bus.resp_ready_in = '1; bus.lc_ready_in = 1'b1; bus.lc_valid_in = 1'b0;
    bus.lc_addr_in = '0; bus.lc_value_in = '0;
    #1 bus.req_valid_in = 2'b01;
    #1 chk("rst_req_ready", LB'(bus.req_ready_out), '0);
    chk("rst_lc_valid", LB'(bus.lc_valid_out), '0);
    chk("rst_resp_valid", LB'(bus.resp_valid_out), '0);
    bus.req_valid_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // single read from port 0
    do_req(0, 0, 64'h1000, '0);
    @(negedge clk);
    chk("t1_lc_valid", LB'(bus.lc_valid_out), LB'(1));
    chk("t1_lc_addr", LB'(bus.lc_addr_out), LB'(64'h1000));
    chk("t1_lc_we", LB'(bus.lc_we_out), '0);
    respond(64'h1000, {64{8'hAB}}, 1);
    chk("t1_resp_valid", LB'(bus.resp_valid_out), LB'(2'b01));
    chk("t1_resp_value", bus.resp_value_out, {64{8'hAB}});
    @(negedge clk);
    chk("t1_idle_resp", LB'(bus.resp_valid_out), '0);
    // write eviction from port 1 with the lower level stalled
    bus.lc_ready_in = 1'b0;
    do_req(1, 1, 64'h2040, {8{64'hDEAD_BEEF_0000_2040}});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_lc_valid", LB'(bus.lc_valid_out), LB'(1));
      chk("t2_lc_we", LB'(bus.lc_we_out), LB'(1));
      chk("t2_lc_addr", LB'(bus.lc_addr_out), LB'(64'h2040));
      chk("t2_lc_value", bus.lc_value_out, {8{64'hDEAD_BEEF_0000_2040}});
    end
    bus.lc_ready_in = 1'b1;
    @(negedge clk);
    chk("t2_lc_drop", LB'(bus.lc_valid_out), '0);
    chk("t2_no_resp", LB'(bus.resp_valid_out), '0);
    // both ports continuously requesting reads
    n_ord = 0;
    fork
      begin
        @(posedge clk); #1;
        bus.req_we_in = '0; bus.req_addr_in[0] = 64'h3000; bus.req_addr_in[1] = 64'h3040;
        bus.req_valid_in = 2'b11;
        for (t = 0; t < 200 && n_ord < 4; t++) begin
          @(negedge clk);
          if (bus.req_ready_out != '0) begin ord[n_ord] = bus.req_ready_out[1] ? 1 : 0; n_ord++; end
        end
        @(posedge clk); #1;
        bus.req_valid_in = '0;
      end
      begin
        for (int j = 0; j < 4; j++) begin
          int w;
          for (w = 0; w < 200; w++) begin @(negedge clk); if (bus.lc_valid_out) break; end
          a = bus.lc_addr_out;
          respond(a, {8{a}}, 0);
        end
      end
    join
    chk("t3_grants", LB'(n_ord), LB'(4));
    chk("t3_order", LB'({ord[0][1:0], ord[1][1:0], ord[2][1:0], ord[3][1:0]}), LB'(8'b00_01_00_01));
    // response backpressure with a pending port 1 read
    v4 = {16{32'hC0FF_EE04}};
    bus.resp_ready_in = 2'b10;
    do_req(0, 0, 64'h4000, '0);
    fork
      do_req(1, 0, 64'h4040, '0);
      begin
        respond(64'h4000, v4, 0);
        for (int i = 0; i < 3; i++) begin
          chk("t4_resp_valid", LB'(bus.resp_valid_out), LB'(2'b01));
          chk("t4_resp_value", bus.resp_value_out, v4);
          chk("t4_no_grant", LB'(bus.req_ready_out), '0);
          @(negedge clk);
        end
        bus.resp_ready_in = 2'b11;
        respond(64'h4040, {16{32'h0000_4040}}, 0);
        chk("t4_resp1_valid", LB'(bus.resp_valid_out), LB'(2'b10));
        chk("t4_resp1_addr", LB'(bus.resp_addr_out), LB'(64'h4040));
      end
    join
    // asynchronous reset in the middle of a read
    do_req(0, 0, 64'h5000, '0);
    for (t = 0; t < 200; t++) begin @(negedge clk); if (bus.lc_ready_out) break; end
    #2 bus.req_addr_in[0] = 64'h6000; bus.req_addr_in[1] = 64'h6040; bus.req_valid_in = 2'b11;
    rst_n = 1'b0;
    #1 chk("t5_lc_ready", LB'(bus.lc_ready_out), '0);
    chk("t5_lc_valid", LB'(bus.lc_valid_out), '0);
    chk("t5_resp_valid", LB'(bus.resp_valid_out), '0);
    chk("t5_req_ready", LB'(bus.req_ready_out), '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    bus.lc_valid_in = 1'b1; bus.lc_addr_in = 64'h5000; bus.lc_value_in = '1;
    chk("t5_ptr0_grant", LB'(bus.req_ready_out), LB'(2'b01));
    chk("t5_lc_not_ready", LB'(bus.lc_ready_out), '0);
    @(posedge clk); #1 bus.req_valid_in[0] = 1'b0;
    @(negedge clk);
    bus.lc_valid_in = 1'b0;
    respond(64'h6000, {8{64'h6000}}, 0);
    do_req(1, 0, 64'h6040, '0);
    respond(64'h6040, {8{64'h6040}}, 0);
    chk("t5_resp1_valid", LB'(bus.resp_valid_out), LB'(2'b10));
`ifdef LLC_ARB_TIMEOUT_EN
    // read that never gets lower-level data
    do_req(0, 0, 64'h7000, '0);
    cnt = 0;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.lc_ready_out) cnt++;
      else if (cnt > 0) break;
    end
    chk("t6_wait_cycles", LB'(cnt), LB'(8));
    chk("t6_err", LB'(bus.err_out), LB'(1));
    chk("t6_no_resp", LB'(bus.resp_valid_out), '0);
    do_req(1, 0, 64'h7040, '0);
    respond(64'h7040, {8{64'h7040}}, 0);
    chk("t6_resp1_valid", LB'(bus.resp_valid_out), LB'(2'b10));
`else
    cnt = 0;
    chk("err_tied_low", LB'(bus.err_out), LB'(cnt));
`endif
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/llc_port_arbiter.md
Name: llc_port_arbiter

Overview:
- Shares one lower-level cache/DRAM port among N_REQ higher-level caches, e.g. L1-I and L1-D onto the LLC, or L1 and TLB onto L2.
- Arbitrates round-robin and forwards exactly one transaction at a time.
- For reads, waits for the returned line and routes it back to the requester that issued it.
- Writes (dirty evictions) are fire-and-forget once the lower level accepts them.

Parameters:
- N_REQ, 2, number of requesting caches (>=2).
- B, 64, line size in bytes; line bus width is B*8.
- ADDR_BITS, 64, address width.
- TIMEOUT_CYCLES, 1024, response watchdog limit; used only with the optional feature.

Ports:
- clk_in  input  1  clock
- rst_N_in  input  1  reset, asynchronous, active-low
- req_valid_in  input  N_REQ  per-requester request valid
- req_we_in  input  N_REQ  per-requester write (eviction) flag
- req_addr_in  input  N_REQ x ADDR_BITS  per-requester line address
- req_value_in  input  N_REQ x B*8  per-requester write line
- req_ready_out  output  N_REQ  one-hot request accept
- resp_valid_out  output  N_REQ  one-hot read response valid
- resp_addr_out  output  ADDR_BITS  response address, shared
- resp_value_out  output  B*8  response line, shared
- resp_ready_in  input  N_REQ  per-requester response accept
- lc_valid_out  output  1  request to lower level
- lc_we_out  output  1  write to lower level
- lc_addr_out  output  ADDR_BITS  lower-level address
- lc_value_out  output  B*8  lower-level write line
- lc_ready_in  input  1  lower level accepts request
- lc_valid_in  input  1  lower-level read data valid
- lc_addr_in  input  ADDR_BITS  returned address
- lc_value_in  input  B*8  returned line
- lc_ready_out  output  1  arbiter accepts returned data
- err_out  output  1  sticky timeout error (optional feature)

Behaviour:
- Transfer rule: a transfer occurs on a rising edge where valid and ready are both high. Requesters hold valid and payload stable until accepted.
- Reset: asynchronous on rst_N_in low. All outputs are 0, state is IDLE, RR pointer is 0, the latched request is cleared, and err_out is 0. An in-flight lower-level transaction is abandoned with no replay.
- FSM states: IDLE, ISSUE, WAIT_RESP, RESPOND.
- IDLE:
  - Grant goes to the first i with req_valid_in[i] high, searching from the RR pointer upward modulo N_REQ.
  - req_ready_out[grant] is asserted combinationally in IDLE only.
  - On the edge: latch grant, we, addr and value; pointer <= (grant+1) mod N_REQ; go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE:
  - lc_valid_out, lc_we_out, lc_addr_out and lc_value_out are registered, so they are high from the first ISSUE cycle. Minimum latency from request accept to lc_valid_out is 1 cycle.
  - Hold until lc_ready_in.
  - When accepted: a write goes to IDLE; a read goes to WAIT_RESP. lc_valid_out drops the following cycle.
- WAIT_RESP:
  - lc_ready_out = 1 here only.
  - On lc_valid_in: latch lc_addr_in and lc_value_in, go to RESPOND.
  - Lower-level data outside WAIT_RESP is not accepted (lc_ready_out = 0).
  - A returned address that differs from the latched line address is still accepted and forwarded. Address checking belongs to the requester.
- RESPOND:
  - resp_valid_out[owner] = 1, registered; resp_addr_out and resp_value_out are driven.
  - Hold until resp_ready_in[owner], then go to IDLE.
  - Non-owner resp_ready_in is ignored.
  - resp_value_out is 0 whenever no resp_valid_out bit is high.
- Only one transaction is outstanding at any time. New requests wait in IDLE.
- Fairness: a continuously requesting port is granted at least once every N_REQ transactions.
- Simultaneous events: req_valid_in high on a port during another port's transaction has no effect until IDLE. The same port may re-request immediately in the cycle it receives its response.
- Widths: grant and pointer are $clog2(N_REQ) bits. Pointer wrap from N_REQ-1 goes to 0, and is correct for non-power-of-2 N_REQ.

Optional Feature:
- Macro: LLC_ARB_TIMEOUT_EN.
- Defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entering WAIT_RESP and increments each WAIT_RESP cycle.
  - At TIMEOUT_CYCLES it sets err_out (sticky until reset) and returns to IDLE with no response to the owner.
- Undefined: no counter; err_out is tied to 0; WAIT_RESP waits indefinitely.

Decomposition:
- Package llc_arb_pkg holds the state enum arb_state_t (IDLE, ISSUE, WAIT_RESP, RESPOND) and a line_t typedef parameterised via localparam LINE_BITS = B*8 default.
- Sub-module rr_arbiter (parameter N; inputs req vector and pointer; outputs grant index and grant_valid) is purely combinational priority logic. The pointer register stays in the parent.

Test Plan:
- Single read: port0 requests read 0x1000 -> lc_valid_out next cycle with addr 0x1000, we=0. lc_valid_in with line 0xAB.. two cycles later -> resp_valid_out=2'b01, resp_value_out=0xAB.., then IDLE.
- Round-robin: both ports hold valid reads continuously -> grant order 0,1,0,1 across four transactions. Each response is routed only to its issuer.
- Write eviction: port1 writes 0x2040 with lc_ready_in stalled 5 cycles -> lc_valid_out held 5 cycles with stable payload. After accept, no response; req_ready_out goes back to port0/port1 within 2 cycles.
- Response backpressure: resp_ready_in[0] low 3 cycles -> resp_valid_out/value held stable. A pending port1 request is not granted until after the handshake.
- Reset mid-WAIT_RESP: assert rst_N_in low asynchronously -> all outputs 0 immediately, pointer 0. A later lc_valid_in is not accepted (lc_ready_out=0).
- With LLC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: a read issued with no lc_valid_in -> err_out rises after 8 WAIT_RESP cycles, FSM returns to IDLE, and the next request is served normally.
